johnson_phase_decoder: RTL and testbench
========================================

Name: johnson_phase_decoder

Overview:
- Consumes the N-bit Johnson code from the structural Johnson ring counter and turns it into usable phase information.
- Produces a binary phase index and a one-hot phase vector, both registered.
- Checks each sampled code for illegal values and for illegal sequence jumps.
- Runs a lock state machine, keeps a sticky error flag, and counts full revolutions. Sits directly downstream of the counter; feeds phase-sequenced control logic.

Parameters:
- N, 4, Johnson counter width; 2N phases, N >= 2.
- LOCK_CNT, 4, number of consecutive legal advances needed to declare lock, >= 1.
- REV_W, 8, revolution counter width.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  reset, asynchronous and active-low.
- din  input  N  Johnson code from the counter, MSB first.
- err_clr  input  1  synchronous clear of err_sticky.
- phase_idx  output  $clog2(2N)  decoded phase, 0..2N-1.
- phase_oh  output  2N  one-hot phase, bit phase_idx set; all-zero when not valid.
- phase_vld  output  1  registered code-legal flag for the current outputs.
- lock  output  1  high in LOCK state.
- code_err  output  1  one-cycle pulse, illegal code seen.
- seq_err  output  1  one-cycle pulse, legal code that is not a hold or successor.
- err_sticky  output  1  set by any error while in ACQ or LOCK.
- rev_cnt  output  REV_W  completed revolutions while locked; wraps.

Behaviour:
- Reset (rst low, asynchronous) zeroes all registers and outputs.
  - This includes din_q, prev_q, phase_idx, phase_oh, phase_vld, lock, code_err, seq_err, err_sticky, rev_cnt and the lock counter.
  - FSM state goes to UNLOCK.
  - Reset deassertion mid-sequence does not cause an error; there is no prior code to compare against.
- Stage 1: din registered into din_q every clock. prev_q holds the previous din_q, marked valid after the first post-reset sample.
- Legality: a code is legal iff scanning MSB to LSB there is at most one bit change. That gives exactly 2N legal codes; everything else is illegal.
- Decode:
  - If din_q[0]==0, idx = popcount(din_q).
  - Otherwise, idx = 2N - popcount(din_q).
  - For N=4: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7.
- Stage 2 (registered, total latency 2 clocks from din to outputs):
  - phase_vld = legal.
  - phase_idx = idx when legal, else holds its last value.
  - phase_oh = one-hot(idx) when legal, else all-zero.
- Transition classification (only when prev_q is valid and both codes are legal):
  - Hold: idx == prev idx. Allowed; the counter may stall.
  - Advance: idx == (prev idx + 1) mod 2N.
  - Anything else raises seq_err.
  - If the current code is illegal, code_err is raised and no seq_err in that cycle.
  - The comparison following an illegal code does not raise seq_err; the next legal code re-seeds the reference.
- FSM:
  - UNLOCK: on a legal code, go to ACQ and clear the lock counter.
  - ACQ: each advance increments the counter; hold leaves it unchanged. An advance that makes the count equal LOCK_CNT goes to LOCK. Any error goes to UNLOCK.
  - LOCK: lock=1. Any error goes to UNLOCK and lock drops on the same edge that registers the error pulse.
- err_sticky:
  - Set on any code_err or seq_err while in ACQ or LOCK.
  - Errors in UNLOCK do not set it.
  - Cleared by err_clr; if set and clear happen in the same cycle, set wins.
- rev_cnt: increments on an advance from idx 2N-1 to 0 while in LOCK. Wraps from all-ones to 0. It is not cleared on loss of lock; only reset clears it.

Decomposition:
- Shared package holds:
  - FSM state encoding (UNLOCK=2'd0, ACQ=2'd1, LOCK=2'd2).
  - Phase index width function clog2(2N).
  - A Johnson legality/decode function reusable by other Johnson-code consumers.
- One sub-module is natural: johnson_code_decode, a combinational N-bit code to {legal, idx} decoder, instantiated once.
- Registers, classification, FSM and counters live in the top module.

Test Plan:
- Free-running code, N=4, LOCK_CNT=4:
  - Drive 0000,1000,1100,1110,1111 on consecutive clocks.
  - phase_idx reaches 0..4 two clocks after each code.
  - lock rises after the 4th advance.
  - No error pulses.
- Hold tolerance: while locked, repeat 1100 for 3 clocks then continue to 1110 -> lock stays 1, phase_oh stays 8'b0000_0100 during the hold, then becomes 8'b0000_1000, no errors.
- Illegal code: while locked, inject 1010 for one clock.
  - code_err pulses once.
  - phase_vld=0 and phase_oh=0 for one cycle.
  - lock drops and err_sticky=1.
  - Relock occurs after 4 further advances.
- Sequence jump: while locked, go 1000 -> 1110.
  - seq_err pulses once, lock drops, err_sticky=1.
  - err_clr pulsed later clears err_sticky.
  - err_clr pulsed in the same cycle as a new error leaves err_sticky=1.
- Revolutions:
  - Run 3 full cycles (0001->0000 wraps) after lock -> rev_cnt=3.
  - With REV_W=2, 5 revolutions -> rev_cnt=1.
- Async reset mid-sequence:
  - Assert rst low between clock edges while locked -> all outputs 0 immediately.
  - After release, the first code sampled raises no error.

Source files
------------

// File: rtl/johnson_phase_decoder_pkg.sv
// Shared definitions for consumers of Johnson ring-counter codes:
// lock FSM encoding, phase index sizing, and code legality/decode helpers.
package johnson_phase_decoder_pkg;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // Widest Johnson code the helpers accept; callers zero-extend narrower codes.
    localparam int unsigned JW_MAX = 32;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    // Legal iff at most one bit change when scanning the n-bit code end to end.
    function automatic logic johnson_legal(input logic [JW_MAX-1:0] code, input int unsigned n);
        int unsigned changes;
        changes = 0;
        for (int unsigned i = 1; i < n; i++) begin
            if (code[i] != code[i-1]) changes++;
        end
        return (changes <= 1);
    endfunction

    function automatic int unsigned johnson_idx(input logic [JW_MAX-1:0] code, input int unsigned n);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (code[i]) ones++;
        end
        return code[0] ? (2 * n - ones) : ones;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Code input and phase/status outputs of the Johnson phase decoder.
interface johnson_phase_decoder_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned REV_W = 8
);
    localparam int unsigned IW = johnson_phase_decoder_pkg::idx_width(N);

    logic [N-1:0]     din;
    logic             err_clr;
    logic [IW-1:0]    phase_idx;
    logic [2*N-1:0]   phase_oh;
    logic             phase_vld;
    logic             lock;
    logic             code_err;
    logic             seq_err;
    logic             err_sticky;
    logic [REV_W-1:0] rev_cnt;

    modport master (
        output din, err_clr,
        input  phase_idx, phase_oh, phase_vld, lock, code_err, seq_err, err_sticky, rev_cnt
    );

    modport slave (
        input  din, err_clr,
        output phase_idx, phase_oh, phase_vld, lock, code_err, seq_err, err_sticky, rev_cnt
    );

endinterface

// File: rtl/johnson_phase_decoder_code_decode.sv
// Combinational N-bit Johnson code to {legal, phase index} decoder.
module johnson_code_decode
    import johnson_phase_decoder_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] idx
);

    always_comb begin
        legal = johnson_legal(JW_MAX'(code), N);
        idx   = IW'(johnson_idx(JW_MAX'(code), N));
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers and decodes the Johnson counter code, classifies each step,
// and tracks lock, sticky error and completed revolutions.
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned REV_W    = 8
) (
    input logic                    clk,
    input logic                    rst,
    johnson_phase_decoder_if.slave bus
);

    localparam int unsigned   IW       = idx_width(N);
    localparam int unsigned   PH       = 2 * N;
    localparam int unsigned   CW       = $clog2(LOCK_CNT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(PH - 1);

    logic [N-1:0]     din_q;
    logic             din_vld_q;
    logic             prev_vld_q;
    logic             prev_legal_q;
    logic [IW-1:0]    prev_idx_q;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n, cnt_inc;
    logic [REV_W-1:0] rev_q, rev_n;
    logic             sticky_q, sticky_n;

    logic [IW-1:0]    phase_idx_q;
    logic [PH-1:0]    phase_oh_q;
    logic             phase_vld_q;
    logic             code_err_q;
    logic             seq_err_q;

    logic             legal;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    succ;
    logic [PH-1:0]    oh;
    logic             cmp, hold, adv;
    logic             code_err_n, seq_err_n, err_any;

    johnson_code_decode #(.N(N)) u_decode (
        .code  (din_q),
        .legal (legal),
        .idx   (idx)
    );

    always_comb begin
        oh      = '0;
        oh[idx] = 1'b1;
        succ    = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + 1'b1;
        // An illegal previous code leaves no reference, so the next legal code re-seeds it.
        cmp     = din_vld_q && prev_vld_q && prev_legal_q && legal;
        hold    = cmp && (idx == prev_idx_q);
        adv     = cmp && (idx == succ);
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        cnt_inc    = cnt_q + 1'b1;
        rev_n      = rev_q;
        code_err_n = din_vld_q && !legal;
        seq_err_n  = cmp && !hold && !adv;
        err_any    = code_err_n || seq_err_n;

        if (din_vld_q) begin
            case (state_q)
                UNLOCK: begin
                    if (legal) begin
                        state_n = ACQ;
                        cnt_n   = '0;
                    end
                end
                ACQ: begin
                    if (err_any) begin
                        state_n = UNLOCK;
                    end else if (adv) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(LOCK_CNT)) state_n = LOCK;
                    end
                end
                LOCK: begin
                    if (err_any) begin
                        state_n = UNLOCK;
                    end else if (adv && (prev_idx_q == LAST_IDX)) begin
                        rev_n = rev_q + 1'b1;
                    end
                end
                default: state_n = UNLOCK;
            endcase
        end

        // A new error outranks a simultaneous clear.
        sticky_n = (err_any && (state_q != UNLOCK)) || (sticky_q && !bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q        <= '0;
            din_vld_q    <= 1'b0;
            prev_vld_q   <= 1'b0;
            prev_legal_q <= 1'b0;
            prev_idx_q   <= '0;
            state_q      <= UNLOCK;
            cnt_q        <= '0;
            rev_q        <= '0;
            sticky_q     <= 1'b0;
            phase_idx_q  <= '0;
            phase_oh_q   <= '0;
            phase_vld_q  <= 1'b0;
            code_err_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            din_q        <= bus.din;
            din_vld_q    <= 1'b1;
            prev_vld_q   <= din_vld_q;
            prev_legal_q <= legal;
            prev_idx_q   <= idx;
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            rev_q        <= rev_n;
            sticky_q     <= sticky_n;
            code_err_q   <= code_err_n;
            seq_err_q    <= seq_err_n;
            phase_vld_q  <= din_vld_q && legal;
            phase_oh_q   <= (din_vld_q && legal) ? oh : '0;
            if (din_vld_q && legal) phase_idx_q <= idx;
        end
    end

    assign bus.phase_idx  = phase_idx_q;
    assign bus.phase_oh   = phase_oh_q;
    assign bus.phase_vld  = phase_vld_q;
    assign bus.lock       = (state_q == LOCK);
    assign bus.code_err   = code_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.rev_cnt    = rev_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder: directed Johnson code sequences,
// plus a REV_W=2 instance sharing the same stimulus for revolution wrap.
module tb_johnson_phase_decoder;

    localparam int unsigned N        = 4;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned REV_W    = 8;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       lock;
        logic       cerr;
        logic       serr;
        logic       stk;
        logic [7:0] rev;
        logic [1:0] rev2;
    } exp_t;

    typedef struct {
        exp_t e;
        int   due;
        int   id;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   nvec = 0;
    logic pend_clr = 1'b0;
    sb_t  sb[$];
    logic [3:0] jc [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    johnson_phase_decoder_if #(.N(N), .REV_W(REV_W)) bus ();
    johnson_phase_decoder_if #(.N(N), .REV_W(2))     bus2 ();

    johnson_phase_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    johnson_phase_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .REV_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.din     = bus.din;
    assign bus2.err_clr = bus.err_clr;

    function automatic exp_t sample();
        exp_t a;
        a.vld  = bus.phase_vld;
        a.idx  = bus.phase_idx;
        a.oh   = bus.phase_oh;
        a.lock = bus.lock;
        a.cerr = bus.code_err;
        a.serr = bus.seq_err;
        a.stk  = bus.err_sticky;
        a.rev  = bus.rev_cnt;
        a.rev2 = bus2.rev_cnt;
        return a;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got vld=%0b idx=%0d oh=%b lock=%0b cerr=%0b serr=%0b stk=%0b rev=%0d rev2=%0d, want vld=%0b idx=%0d oh=%b lock=%0b cerr=%0b serr=%0b stk=%0b rev=%0d rev2=%0d",
                     name, a.vld, a.idx, a.oh, a.lock, a.cerr, a.serr, a.stk, a.rev, a.rev2,
                     e.vld, e.idx, e.oh, e.lock, e.cerr, e.serr, e.stk, e.rev, e.rev2);
        end
    endtask

    // Drive one code; clr is applied to the output stage of this same code.
    task automatic step(input logic [3:0] code, input logic clr, input logic vld, input int idx,
                        input logic lk, input logic ce, input logic se, input logic sk, input int rv);
        exp_t e;
        @(negedge clk);
        bus.err_clr = pend_clr;
        pend_clr    = clr;
        bus.din     = code;
        e.vld  = vld;
        e.idx  = 3'(idx);
        e.oh   = vld ? (8'd1 << idx) : 8'd0;
        e.lock = lk;
        e.cerr = ce;
        e.serr = se;
        e.stk  = sk;
        e.rev  = 8'(rv);
        e.rev2 = 2'(rv % 4);
        sb.push_back('{e, cyc + 2, nvec});
        nvec++;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        #1;
        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t s;
            s = sb.pop_front();
            check($sformatf("vec%0d", s.id), sample(), s.e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        jc = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
        bus.din     = '0;
        bus.err_clr = 1'b0;
        #1 rst = 1'b0;
        #2 check("reset", sample(), '0);

        // Acquire: four advances after the first legal code give lock.
        step(jc[0], 0, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(jc[1], 0, 1, 1, 0, 0, 0, 0, 0);
        step(jc[2], 0, 1, 2, 0, 0, 0, 0, 0);
        step(jc[3], 0, 1, 3, 0, 0, 0, 0, 0);
        step(jc[4], 0, 1, 4, 1, 0, 0, 0, 0);

        // Five revolutions while locked; rev counts on each 7->0 step.
        for (int r = 1; r <= 5; r++) begin
            for (int k = 5; k < 13; k++) begin
                step(jc[k % 8], 0, 1, k % 8, 1, 0, 0, 0, ((k % 8) < 5) ? r : r - 1);
            end
        end

        // Hold on 1100 for three clocks.
        step(jc[5], 0, 1, 5, 1, 0, 0, 0, 5);
        step(jc[6], 0, 1, 6, 1, 0, 0, 0, 5);
        step(jc[7], 0, 1, 7, 1, 0, 0, 0, 5);
        step(jc[0], 0, 1, 0, 1, 0, 0, 0, 6);
        step(jc[1], 0, 1, 1, 1, 0, 0, 0, 6);
        step(jc[2], 0, 1, 2, 1, 0, 0, 0, 6);
        step(jc[2], 0, 1, 2, 1, 0, 0, 0, 6);
        step(jc[2], 0, 1, 2, 1, 0, 0, 0, 6);
        step(jc[3], 0, 1, 3, 1, 0, 0, 0, 6);

        // Illegal code while locked, then relock; clear sticky along the way.
        step(4'b1010, 0, 0, 3, 0, 1, 0, 1, 6);
        step(jc[4], 0, 1, 4, 0, 0, 0, 1, 6);
        step(jc[5], 0, 1, 5, 0, 0, 0, 1, 6);
        step(jc[6], 1, 1, 6, 0, 0, 0, 0, 6);
        step(jc[7], 0, 1, 7, 0, 0, 0, 0, 6);
        step(jc[0], 0, 1, 0, 1, 0, 0, 0, 6);

        // Sequence jump while locked, clear, then error and clear together.
        step(jc[1], 0, 1, 1, 1, 0, 0, 0, 6);
        step(jc[3], 0, 1, 3, 0, 0, 1, 1, 6);
        step(jc[4], 0, 1, 4, 0, 0, 0, 1, 6);
        step(jc[5], 1, 1, 5, 0, 0, 0, 0, 6);
        step(jc[7], 1, 1, 7, 0, 0, 1, 1, 6);
        step(jc[0], 0, 1, 0, 0, 0, 0, 1, 6);

        // Errors in UNLOCK do not set sticky, so a clear there wins.
        step(jc[1], 1, 1, 1, 0, 0, 0, 0, 6);
        step(4'b1010, 0, 0, 1, 0, 1, 0, 1, 6);
        step(4'b0110, 1, 0, 1, 0, 1, 0, 0, 6);
        step(jc[2], 0, 1, 2, 0, 0, 0, 0, 6);
        step(jc[3], 0, 1, 3, 0, 0, 0, 0, 6);
        step(jc[4], 0, 1, 4, 0, 0, 0, 0, 6);
        step(jc[5], 0, 1, 5, 0, 0, 0, 0, 6);
        step(jc[6], 0, 1, 6, 1, 0, 0, 0, 6);
        drain();

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", sample(), '0);
        step(jc[5], 0, 1, 5, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(jc[6], 0, 1, 6, 0, 0, 0, 0, 0);
        step(jc[0], 0, 1, 0, 0, 0, 1, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
